// File: rtl/alu_seq.sv
// Sequential ALU for the accumulator datapath: single-cycle logic/arith ops plus
// WIDTH-iteration signed multiply and divide over a shared shift datapath.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int OP_W  = 4,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OP_W-1:0]  opcode,
  input  logic [WIDTH-1:0] acc2alu,
  input  logic [WIDTH-1:0] br2alu,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu2acc,
  output logic [WIDTH-1:0] mr_data,
  output logic [4:0]       alu_flags
);
  localparam logic [OP_W-1:0] OP_CLR = OP_W'(1),  OP_ADD = OP_W'(2),  OP_SUB = OP_W'(3);
  localparam logic [OP_W-1:0] OP_MPY = OP_W'(4),  OP_AND = OP_W'(5),  OP_OR  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_NOT = OP_W'(7),  OP_SHL = OP_W'(8),  OP_SHR = OP_W'(9);
  localparam logic [OP_W-1:0] OP_SAR = OP_W'(10), OP_DIV = OP_W'(11);
  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t state;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rem_q;          // upper partial product / partial remainder
  logic [WIDTH-1:0] qr;             // multiplier / dividend bits, shifted each iteration
  logic [WIDTH-1:0] mag;            // multiplicand / divisor magnitude
  logic             neg_res, neg_rem, ovf;

  logic [WIDTH-1:0] a, b, a_mag, b_mag, add_r, sub_r, s_lo;
  logic             s_v, s_wr, last;

  assign a     = acc2alu;
  assign b     = br2alu;
  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;
  assign add_r = a + b;
  assign sub_r = a - b;
  assign busy  = (state != IDLE);
  assign last  = (cnt == CNT_W'(WIDTH-1));

  always_comb begin
    s_lo = '0;
    s_v  = 1'b0;
    s_wr = 1'b1;
    case (opcode)
      OP_CLR: ;
      OP_ADD: begin
        s_lo = add_r;
        s_v  = (a[WIDTH-1] == b[WIDTH-1]) && (add_r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        s_lo = sub_r;
        s_v  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: s_lo = a & b;
      OP_OR:  s_lo = a | b;
      OP_NOT: s_lo = ~a;
      OP_SHL: begin
        s_lo = {a[WIDTH-2:0], 1'b0};
        s_v  = a[WIDTH-1] ^ a[WIDTH-2];
      end
      OP_SHR: s_lo = {1'b0, a[WIDTH-1:1]};
      OP_SAR: s_lo = {a[WIDTH-1], a[WIDTH-1:1]};
      default: s_wr = 1'b0;
    endcase
  end

  // Unsigned iteration on magnitudes; sign is applied once on the final edge.
  logic [WIDTH:0]     mul_sum, mul_r, sh_r, trial, div_r;
  logic [WIDTH-1:0]   mul_q, div_q, quo_s, rem_s;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic               ge;

  always_comb begin
    mul_sum = qr[0] ? rem_q + {1'b0, mag} : rem_q;
    mul_r   = {1'b0, mul_sum[WIDTH:1]};
    mul_q   = {mul_sum[0], qr[WIDTH-1:1]};
    sh_r    = {rem_q[WIDTH-1:0], qr[WIDTH-1]};
    trial   = sh_r - {1'b0, mag};
    ge      = (sh_r >= {1'b0, mag});
    div_r   = ge ? trial : sh_r;
    div_q   = {qr[WIDTH-2:0], ge};
    prod    = {mul_r[WIDTH-1:0], mul_q};
    prod_s  = neg_res ? -prod : prod;
    quo_s   = neg_res ? -div_q : div_q;
    rem_s   = neg_rem ? -div_r[WIDTH-1:0] : div_r[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rem_q     <= '0;
      qr        <= '0;
      mag       <= '0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      ovf       <= 1'b0;
      alu2acc   <= '0;
      mr_data   <= '0;
      alu_flags <= 5'b00010;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          cnt     <= '0;
          rem_q   <= '0;
          neg_res <= a[WIDTH-1] ^ b[WIDTH-1];
          neg_rem <= a[WIDTH-1];
          if (opcode == OP_MPY) begin
            state <= MUL;
            mag   <= a_mag;
            qr    <= b_mag;
            ovf   <= 1'b0;
          end else if (opcode == OP_DIV && b != '0) begin
            state <= DIV;
            mag   <= b_mag;
            qr    <= a_mag;
            ovf   <= (a == MIN_V) && (b == '1);
          end else begin
            done <= 1'b1;
            if (opcode == OP_DIV) begin
              alu2acc   <= '1;
              mr_data   <= a;
              alu_flags <= 5'b11101;
            end else if (s_wr) begin
              alu2acc   <= s_lo;
              mr_data   <= '0;
              alu_flags <= {2'b00, s_v, s_lo == '0, s_lo[WIDTH-1]};
            end
          end
        end
        MUL: begin
          cnt   <= cnt + CNT_W'(1);
          rem_q <= mul_r;
          qr    <= mul_q;
          if (last) begin
            state                <= IDLE;
            done                 <= 1'b1;
            {mr_data, alu2acc}   <= prod_s;
            alu_flags            <= {2'b01, 1'b0, prod_s == '0, prod_s[2*WIDTH-1]};
          end
        end
        DIV: begin
          cnt   <= cnt + CNT_W'(1);
          rem_q <= div_r;
          qr    <= div_q;
          if (last) begin
            state     <= IDLE;
            done      <= 1'b1;
            alu2acc   <= quo_s;
            mr_data   <= rem_s;
            alu_flags <= {2'b01, ovf, quo_s == '0, quo_s[WIDTH-1]};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Randomized + directed bench for alu_seq (WIDTH=16 and WIDTH=8 instances)
// against an arithmetic reference model.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [3:0]  opcode = '0;
  logic [15:0] acc = '0, br = '0, lo, hi;
  logic        busy, done;
  logic [4:0]  fl;

  logic        start8 = 1'b0;
  logic [3:0]  opcode8 = '0;
  logic [7:0]  acc8 = '0, br8 = '0, lo8, hi8;
  logic        busy8, done8;
  logic [4:0]  fl8;

  alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
    .acc2alu(acc), .br2alu(br), .busy(busy), .done(done),
    .alu2acc(lo), .mr_data(hi), .alu_flags(fl));

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .opcode(opcode8),
    .acc2alu(acc8), .br2alu(br8), .busy(busy8), .done(done8),
    .alu2acc(lo8), .mr_data(hi8), .alu_flags(fl8));

  int n_chk = 0, n_fail = 0;
  logic [15:0] e_lo = '0, e_hi = '0;
  logic [4:0]  e_fl = 5'b00010;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Updates expected state from signed integer arithmetic; returns busy cycles.
  function automatic int model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    longint sa, sb, r, m;
    logic   v;
    sa = $signed(a);
    sb = $signed(b);
    v  = 1'b0;
    case (op)
      4'd1: begin e_lo = '0; e_hi = '0; e_fl = 5'b00010; return 0; end
      4'd2, 4'd3, 4'd8: begin
        r    = (op == 4'd2) ? sa + sb : (op == 4'd3) ? sa - sb : sa * 2;
        v    = (r > 32767) || (r < -32768);
        e_lo = r[15:0];
      end
      4'd4: begin
        r    = sa * sb;
        e_hi = r[31:16];
        e_lo = r[15:0];
        e_fl = {2'b01, 1'b0, r == 0, r < 0};
        return 16;
      end
      4'd5:  e_lo = a & b;
      4'd6:  e_lo = a | b;
      4'd7:  e_lo = ~a;
      4'd9:  e_lo = a >> 1;
      4'd10: begin r = sa >>> 1; e_lo = r[15:0]; end
      4'd11: begin
        if (b == 16'd0) begin
          e_lo = 16'hFFFF; e_hi = a; e_fl = 5'b11101;
          return 0;
        end
        r    = sa / sb;
        m    = sa % sb;
        e_lo = r[15:0];
        e_hi = m[15:0];
        e_fl = {2'b01, r > 32767, e_lo == 16'd0, e_lo[15]};
        return 16;
      end
      default: return 0;
    endcase
    e_hi = '0;
    e_fl = {2'b00, v, e_lo == 16'd0, e_lo[15]};
    return 0;
  endfunction

  task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input bit poke, input bit tail);
    logic [15:0] p_lo, p_hi;
    int lat;
    p_lo = e_lo;
    p_hi = e_hi;
    lat  = model(op, a, b);
    @(negedge clk);
    start = 1'b1; opcode = op; acc = a; br = b;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= lat; i++) begin
      chk("busy", 32'(busy), 32'd1);
      chk("done_early", 32'(done), 32'd0);
      chk("hold_lo", 32'(lo), 32'(p_lo));
      chk("hold_hi", 32'(hi), 32'(p_hi));
      if (poke && i == 3) begin
        start = 1'b1; opcode = 4'd2; acc = 16'($urandom); br = 16'($urandom);
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("done", 32'(done), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk("lo", 32'(lo), 32'(e_lo));
    chk("hi", 32'(hi), 32'(e_hi));
    chk("flags", 32'(fl), 32'(e_fl));
    if (tail) begin
      @(posedge clk); #1;
      chk("done_pulse", 32'(done), 32'd0);
    end
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h8000;
      2: return 16'hFFFF;
      3: return 16'h7FFF;
      4: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_lo", 32'(lo), 32'd0);
    chk("rst_hi", 32'(hi), 32'd0);
    chk("rst_flags", 32'(fl), 32'b00010);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(4'd2, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
    chk("add_ovf_lo", 32'(lo), 32'h8000);
    chk("add_ovf_flags", 32'(fl), 32'b00101);
    do_op(4'd4, 16'hFFFD, 16'h0005, 1'b1, 1'b1);
    chk("mpy_const", 32'({hi, lo}), 32'hFFFF_FFF1);
    do_op(4'd11, 16'hFFF9, 16'h0002, 1'b0, 1'b1);
    do_op(4'd11, 16'h8000, 16'hFFFF, 1'b0, 1'b0);
    do_op(4'd11, 16'h0005, 16'h0000, 1'b0, 1'b1);
    chk("div0_flags", 32'(fl), 32'b11101);
    do_op(4'd3, 16'h0005, 16'h0005, 1'b0, 1'b0);
    do_op(4'd8, 16'h4000, 16'h0000, 1'b0, 1'b0);
    do_op(4'd10, 16'h8001, 16'h0000, 1'b0, 1'b0);
    chk("sar_const", 32'(lo), 32'hC000);
    do_op(4'd0, 16'h1234, 16'h5678, 1'b0, 1'b0);
    do_op(4'd1, 16'h1234, 16'h5678, 1'b0, 1'b1);

    for (int k = 0; k < 80; k++)
      do_op(4'($urandom_range(0, 15)), pick(), pick(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));

    // Reset in the middle of a multiply
    do_op(4'd2, 16'h0102, 16'h0304, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b1; opcode = 4'd4; acc = 16'hFFFD; br = 16'h0005;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_lo", 32'(lo), 32'd0);
    chk("abort_hi", 32'(hi), 32'd0);
    chk("abort_flags", 32'(fl), 32'b00010);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    e_lo = '0; e_hi = '0; e_fl = 5'b00010;
    repeat (20) begin
      @(posedge clk); #1;
      chk("no_stray_done", 32'(done), 32'd0);
    end
    do_op(4'd2, 16'h0010, 16'h0020, 1'b0, 1'b1);

    // WIDTH=8 instance
    @(negedge clk);
    start8 = 1'b1; opcode8 = 4'd2; acc8 = 8'h7F; br8 = 8'h01;
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("w8_add_done", 32'(done8), 32'd1);
    chk("w8_add_lo", 32'(lo8), 32'h80);
    chk("w8_add_flags", 32'(fl8), 32'b00101);
    @(negedge clk);
    start8 = 1'b1; opcode8 = 4'd4; acc8 = 8'hFD; br8 = 8'h05;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk("w8_busy", 32'(busy8), 32'd1);
      chk("w8_done_early", 32'(done8), 32'd0);
      @(posedge clk); #1;
    end
    chk("w8_mpy_done", 32'(done8), 32'd1);
    chk("w8_mpy_busy", 32'(busy8), 32'd0);
    chk("w8_mpy_res", 32'({hi8, lo8}), 32'hFFF1);
    chk("w8_mpy_flags", 32'(fl8), 32'b01001);
    @(posedge clk); #1;
    chk("w8_done_pulse", 32'(done8), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
